// File: rtl/inst_fetch.sv
// Instruction fetch unit.
// Issues one outstanding word fetch at a time to the memory controller and
// buffers each returned word, together with its PC, in a small FIFO for decode.
// A redirect flushes the FIFO. If a request is still in flight when the
// redirect arrives, that request completes normally and its data is discarded.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  // memory controller fetch port
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_done,
  input  logic [DATA_WIDTH-1:0] if_data,
  // redirect
  input  logic                  br_valid,
  input  logic [ADDR_WIDTH-1:0] br_target,
  // decoder side
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);

  localparam int                    PTR_W   = $clog2(DEPTH);
  localparam int                    CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_M = ~ADDR_WIDTH'(3);

  // IDLE: no request. REQ: request in flight, its word is kept.
  // DROP: request in flight, its word is discarded because of a redirect.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_addr_q, if_addr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  entry_t                fifo_q [DEPTH];

  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] br_pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [CNT_W-1:0]      count_after_pop;
  logic                  room_idle;
  logic                  room_after_push;
  entry_t                head;

  // Redirect targets are always word aligned; the two low bits are dropped.
  assign br_pc  = br_target & ALIGN_M;
  assign pc_inc = pc_q + PC_STEP;

  // A redirect flushes the FIFO, so a pop in the same cycle has no effect.
  assign pop             = inst_valid && inst_ready && !br_valid;
  assign count_after_pop = count_q - CNT_W'(pop);
  assign room_idle       = count_after_pop < DEPTH_C;
  assign room_after_push = (count_after_pop + CNT_W'(1)) < DEPTH_C;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking (<=) on every flop, so all registers update from pre-edge values.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect has priority, then completion, then issue.
  always_comb begin
    // NOTE: give every signal written in a combinational block a default first. Otherwise a path that skips it infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (br_valid || room_idle) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (br_valid) begin
          state_d = if_done ? REQ : DROP;
        end else if (if_done && !room_after_push) begin
          state_d = IDLE;
        end
      end
      DROP: begin
        if (if_done) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: request port, PC tracking and the FIFO push decision.
  always_comb begin
    if_valid_d = if_valid_q;
    if_addr_d  = if_addr_q;
    pc_d       = pc_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (br_valid) begin
          pc_d       = br_pc;
          if_valid_d = 1'b1;
          if_addr_d  = br_pc;
        end else if (room_idle) begin
          if_valid_d = 1'b1;
          if_addr_d  = pc_q;
        end
      end
      REQ: begin
        if (br_valid) begin
          // The in-flight request stays on the port until done. A word
          // returning in this cycle is dropped and the target is fetched next.
          pc_d = br_pc;
          if (if_done) begin
            if_addr_d = br_pc;
          end
        end else if (if_done) begin
          push = 1'b1;
          pc_d = pc_inc;
          if (room_after_push) begin
            if_addr_d = pc_inc;
          end else begin
            if_valid_d = 1'b0;
          end
        end
      end
      DROP: begin
        // pc_q holds the most recent redirect target. The discarded request
        // stays on the port until it completes.
        if (br_valid) begin
          pc_d = br_pc;
        end
        if (if_done) begin
          if_addr_d = br_valid ? br_pc : pc_q;
        end
      end
      default: begin
        if_valid_d = 1'b0;
        if_addr_d  = pc_q;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a redirect empties the FIFO.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (br_valid) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_addr_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_addr_q  <= if_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage has no reset. count_q gates inst_valid, so a stale entry is never presented.
    if (push) begin
      fifo_q[wr_ptr_q] <= {pc_q, if_data};
    end
  end

  assign head       = fifo_q[rd_ptr_q];
  assign inst_valid = (count_q != '0);
  assign inst       = head.data;
  assign inst_pc    = head.pc;
  assign if_valid   = if_valid_q;
  assign if_addr    = if_addr_q;

  // A request stays stable until done, and the FIFO never holds more than DEPTH entries.
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    (if_valid_q && !if_done) |=> (if_valid_q && $stable(if_addr_q)));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    count_q <= DEPTH_C);

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch.
// A memory model drives if_done/if_data, with random or manually forced latency.
// A negedge monitor tracks the expected decoder stream: after each reset or
// redirect, the PCs run consecutively from the start address. For every
// completed fetch that is still live, the monitor pushes {pc, word} into a
// scoreboard queue. It then compares that queue against the FIFO head and
// checks the request-port timing.
module tb_inst_fetch;

  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [AW-1:0] if_addr;
  logic          if_done = 1'b0;
  logic [DW-1:0] if_data = '0;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          inst_valid;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  always #5 clk = ~clk;

  inst_fetch #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_data   (if_data),
    .br_valid  (br_valid),
    .br_target (br_target),
    .inst_valid(inst_valid),
    .inst      (inst),
    .inst_pc   (inst_pc),
    .inst_ready(inst_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Contents of the model memory
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- memory controller model ----------------
  bit mem_auto = 1'b0;
  bit man_done = 1'b0;
  int lat_max  = 0;
  bit mbusy    = 1'b0;
  int mlat     = 0;

  always @(posedge clk) begin
    #2;
    if (!mem_auto) begin
      mbusy   = 1'b0;
      if_done = man_done;
      if_data = mem_word(if_addr);
    end else begin
      if (if_done) begin
        if_done = 1'b0;
        mbusy   = 1'b0;
      end
      if (!mbusy && if_valid) begin
        mbusy = 1'b1;
        mlat  = int'($urandom_range(lat_max, 0));
      end
      if (mbusy && !if_done) begin
        if (mlat == 0) begin
          if_done = 1'b1;
          if_data = mem_word(if_addr);
        end else begin
          mlat--;
        end
      end
    end
  end

  // ---------------- reference model + monitor ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_fetch      = RESET_PC;
  logic [31:0] req_pc         = '0;
  bit          outstanding    = 1'b0;
  bit          stale          = 1'b0;
  bit          exp_valid_next = 1'b0;
  bit          m_pop, m_done, m_live;
  int          rst_cycles     = 0;
  int          pops           = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (rst_cycles > 0) begin
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_inst_valid", inst_valid, 1'b0);
        check("rst_if_addr", if_addr, RESET_PC);
      end
      rst_cycles++;
      sb.delete();
      outstanding    = 1'b0;
      stale          = 1'b0;
      exp_fetch      = RESET_PC;
      exp_valid_next = 1'b0;
    end else begin
      rst_cycles = 0;
      check("if_valid", if_valid, exp_valid_next);
      check("inst_valid", inst_valid, sb.size() != 0);
      if (inst_valid && sb.size() != 0) begin
        check("inst_pc", inst_pc, sb[0].pc);
        check("inst", inst, sb[0].data);
      end
      if (if_valid) begin
        if (!outstanding) begin
          check("if_addr_issue", if_addr, exp_fetch);
          outstanding = 1'b1;
          req_pc      = exp_fetch;
        end else begin
          check("if_addr_hold", if_addr, req_pc);
        end
      end
      m_pop  = inst_valid && inst_ready && !br_valid;
      m_done = if_done && outstanding;
      m_live = m_done && !stale && !br_valid;
      if (m_pop) pops++;
      if (br_valid) begin
        if (outstanding && !if_done) stale = 1'b1;
        sb.delete();
        exp_fetch = br_target & ~32'h3;
      end else begin
        if (m_pop && sb.size() != 0) void'(sb.pop_front());
        if (m_live) begin
          sb.push_back('{pc: req_pc, data: mem_word(req_pc)});
          exp_fetch = req_pc + 32'd4;
        end
      end
      if (m_done) begin
        outstanding = 1'b0;
        stale       = 1'b0;
      end
      // A held request stays up. Otherwise the next request must follow
      // immediately unless the FIFO is full after this edge.
      exp_valid_next = (if_valid && !if_done) ? 1'b1
                     : (br_valid || (sb.size() < DEPTH));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    mem_auto   = 1'b0;
    man_done   = 1'b0;
    br_valid   = 1'b0;
    inst_ready = 1'b0;
    rst        = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    check("wait_req_timeout", if_valid, 1'b1);
  endtask

  task automatic mem_done();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
  endtask

  initial begin
    int p0;
    int prob;
    rst        = 1'b1;
    br_valid   = 1'b0;
    br_target  = '0;
    inst_ready = 1'b0;
    repeat (3) tick();

    // Steady stream, single-cycle memory: one instruction per cycle
    rst        = 1'b0;
    lat_max    = 0;
    mem_auto   = 1'b1;
    inst_ready = 1'b1;
    repeat (10) tick();
    p0 = pops;
    repeat (20) tick();
    check("steady_rate", pops - p0, 20);

    // Decoder stalled: FIFO fills with 0x0..0xC, then one pop refetches 0x10
    do_reset();
    lat_max  = 0;
    mem_auto = 1'b1;
    repeat (12) tick();
    check("fill_if_valid", if_valid, 1'b0);
    check("fill_inst_valid", inst_valid, 1'b1);
    check("fill_head_pc", inst_pc, 32'h0);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("pop_head_pc", inst_pc, 32'h4);
    check("refill_valid", if_valid, 1'b1);
    check("refill_addr", if_addr, 32'h10);
    repeat (5) tick();
    inst_ready = 1'b1;
    repeat (8) tick();

    // Redirect to 0x103 while 0x8 is in flight, done three cycles later
    do_reset();
    wait_req();
    mem_done();
    mem_done();
    tick();
    br_valid  = 1'b1;
    br_target = 32'h103;
    tick();
    br_valid = 1'b0;
    tick();
    tick();
    check("drop_hold_valid", if_valid, 1'b1);
    check("drop_hold_addr", if_addr, 32'h8);
    mem_done();
    check("drop_next_addr", if_addr, 32'h100);
    check("drop_fifo_empty", inst_valid, 1'b0);
    mem_done();
    check("drop_first_pc", inst_pc, 32'h100);
    check("drop_first_inst", inst, mem_word(32'h100));

    // Redirect to 0x200 together with done and inst_ready
    do_reset();
    wait_req();
    mem_done();
    check("b2_before_valid", inst_valid, 1'b1);
    man_done   = 1'b1;
    br_valid   = 1'b1;
    br_target  = 32'h200;
    inst_ready = 1'b1;
    tick();
    man_done   = 1'b0;
    br_valid   = 1'b0;
    inst_ready = 1'b0;
    check("b2_fifo_empty", inst_valid, 1'b0);
    check("b2_next_valid", if_valid, 1'b1);
    check("b2_next_addr", if_addr, 32'h200);

    // Address wrap: FFFFFFF8, FFFFFFFC, 0
    do_reset();
    lat_max    = 1;
    mem_auto   = 1'b1;
    inst_ready = 1'b1;
    br_valid   = 1'b1;
    br_target  = 32'hFFFF_FFF9;
    tick();
    br_valid = 1'b0;
    repeat (12) tick();

    // Reset with a request in flight; stray done pulses are ignored
    do_reset();
    inst_ready = 1'b1;
    wait_req();
    tick();
    rst = 1'b1;
    tick();
    tick();
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    tick();
    rst      = 1'b0;
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("stray_valid", if_valid, 1'b1);
    check("stray_addr", if_addr, RESET_PC);
    check("stray_fifo_empty", inst_valid, 1'b0);
    mem_auto = 1'b1;
    repeat (10) tick();

    // Random redirects, decoder stalls and memory latency
    do_reset();
    mem_auto = 1'b1;
    for (int ph = 0; ph < 40; ph++) begin
      lat_max = int'($urandom_range(3, 0));
      prob    = int'($urandom_range(100, 10));
      for (int c = 0; c < 100; c++) begin
        br_valid = ($urandom_range(19, 0) == 0);
        if ($urandom_range(7, 0) == 0) br_target = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else                           br_target = $urandom & 32'h0000_0FFF;
        inst_ready = (int'($urandom_range(99, 0)) < prob);
        tick();
      end
    end
    br_valid   = 1'b0;
    inst_ready = 1'b1;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1);
  end

endmodule
